tx_gearbox_feed: RTL and testbench

TX_GEARBOX_FEED -- requirements
Module: tx_gearbox_feed

---
 rtl/tx_gearbox_feed_pkg.sv | 27 ++
 rtl/tx_gearbox_feed_scrambler.sv | 37 +++
 rtl/tx_gearbox_feed.sv | 95 +++++++++
 tb/tb_tx_gearbox_feed.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_gearbox_feed_pkg.sv
// rtl/tx_gearbox_feed_pkg.sv - shared phy constants for the 64b/66b TX gearbox feed
// Purpose: sync header encodings, idle block, gearbox sequence limit, scrambler taps.
// Ports: none (package).
package tx_gearbox_feed_pkg;

    localparam logic [1:0]  HDR_DATA     = 2'b01;
    localparam logic [1:0]  HDR_CTRL     = 2'b10;
    localparam logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E;

    // Gearbox sequence runs 0..SEQ_MAX; the SEQ_MAX slot carries no block.
    localparam logic [5:0]  SEQ_MAX      = 6'd32;

    // x^58 + x^39 + 1 self-synchronous scrambler
    localparam int SCR_TAP_A   = 39;
    localparam int SCR_TAP_B   = 58;
    localparam int SCR_STATE_W = 58;

    typedef enum logic {
        PHASE_LO = 1'b0,
        PHASE_HI = 1'b1
    } phase_e;

    function automatic logic hdr_invalid(input logic [1:0] hdr);
        return (hdr == 2'b00) || (hdr == 2'b11);
    endfunction

endpackage

// File: rtl/tx_gearbox_feed_scrambler.sv
// rtl/tx_gearbox_feed_scrambler.sv - 64-bit per block self-synchronous 64b/66b scrambler
// Purpose: scrambles one 64-bit payload per enabled cycle, bit 0 first.
// Ports: clk, rst_n (async active-low), en (advance state by one block),
//        data_in (plain payload), data_out (scrambled payload, combinational).
module scrambler_64b66b (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [63:0] data_in,
    output logic [63:0] data_out
);
    import tx_gearbox_feed_pkg::*;

    // state[0] holds the most recent scrambled bit, state[j] the bit j+1 back.
    logic [SCR_STATE_W-1:0] state;
    logic [SCR_STATE_W-1:0] next_state;

    always_comb begin
        logic b;
        next_state = state;
        data_out   = '0;
        for (int i = 0; i < 64; i++) begin
            b           = data_in[i] ^ next_state[SCR_TAP_A-1] ^ next_state[SCR_TAP_B-1];
            data_out[i] = b;
            next_state  = {next_state[SCR_STATE_W-2:0], b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= '1;
        end else if (en) begin
            state <= next_state;
        end
    end

endmodule

// File: rtl/tx_gearbox_feed.sv
// rtl/tx_gearbox_feed.sv - feeds 66-bit blocks into the GT TX gearbox as 32-bit words
// Purpose: accepts one block per two-cycle slot, inserts idles, scrambles payload,
//          drives the GT gearbox sequence and pauses on sequence 32.
// Ports: clk_i, rst_n_i (async active-low);
//        s_data_i/s_header_i/s_valid_i/s_ready_o (block source);
//        gtwiz_userdata_tx_o/txheader_o/txsequence_o (GT gearbox);
//        idle_insert_o, header_err_o (status pulses).
module tx_gearbox_feed #(
    parameter bit P_SCRAMBLE = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [63:0] s_data_i,
    input  logic [1:0]  s_header_i,
    input  logic        s_valid_i,
    output logic        s_ready_o,
    output logic [31:0] gtwiz_userdata_tx_o,
    output logic [1:0]  txheader_o,
    output logic [6:0]  txsequence_o,
    output logic        idle_insert_o,
    output logic        header_err_o
);
    import tx_gearbox_feed_pkg::*;

    // run is cleared by reset so s_ready_o stays low until the first edge after release.
    logic        run;
    phase_e      phase;
    logic [5:0]  seq;
    logic        hi_pending;
    logic [31:0] hi_word;

    logic        slot;
    logic [1:0]  blk_hdr;
    logic [63:0] blk_pay;
    logic [63:0] scr_pay;
    logic [63:0] tx_pay;

    assign s_ready_o = run && (phase == PHASE_LO) && (seq != SEQ_MAX);
    assign slot      = s_ready_o;

    // An open slot without a source block carries an idle control block.
    assign blk_hdr = s_valid_i ? s_header_i : HDR_CTRL;
    assign blk_pay = s_valid_i ? s_data_i   : IDLE_PAYLOAD;

    scrambler_64b66b u_scrambler (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .en       (slot && P_SCRAMBLE),
        .data_in  (blk_pay),
        .data_out (scr_pay)
    );

    assign tx_pay       = P_SCRAMBLE ? scr_pay : blk_pay;
    assign txsequence_o = {1'b0, seq};

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            run                 <= 1'b0;
            phase               <= PHASE_LO;
            seq                 <= '0;
            hi_pending          <= 1'b0;
            hi_word             <= '0;
            gtwiz_userdata_tx_o <= '0;
            txheader_o          <= 2'b00;
            idle_insert_o       <= 1'b0;
            header_err_o        <= 1'b0;
        end else begin
            run           <= 1'b1;
            idle_insert_o <= 1'b0;
            header_err_o  <= 1'b0;

            if (run) begin
                phase <= (phase == PHASE_LO) ? PHASE_HI : PHASE_LO;
                if (phase == PHASE_HI) begin
                    seq <= (seq == SEQ_MAX) ? 6'd0 : seq + 6'd1;
                end
            end

            if (slot) begin
                gtwiz_userdata_tx_o <= tx_pay[31:0];
                hi_word             <= tx_pay[63:32];
                hi_pending          <= 1'b1;
                txheader_o          <= blk_hdr;
                idle_insert_o       <= !s_valid_i;
                header_err_o        <= hdr_invalid(blk_hdr);
            end else if (hi_pending) begin
                // Second word of the block; header keeps its value.
                gtwiz_userdata_tx_o <= hi_word;
                hi_pending          <= 1'b0;
            end
            // Otherwise (sequence 32) data and header hold.
        end
    end

endmodule

// File: tb/tb_tx_gearbox_feed.sv
// tb/tb_tx_gearbox_feed.sv - self-checking bench for tx_gearbox_feed
module tb_tx_gearbox_feed;

    localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001E;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [63:0] s_data;
    logic [1:0]  s_header;
    logic        s_valid;

    logic        r0, r1;
    logic [31:0] d0, d1;
    logic [1:0]  h0, h1;
    logic [6:0]  q0, q1;
    logic        i0, i1;
    logic        e0, e1;

    tx_gearbox_feed #(.P_SCRAMBLE(1'b0)) dut_plain (
        .clk_i(clk), .rst_n_i(rst_n), .s_data_i(s_data), .s_header_i(s_header),
        .s_valid_i(s_valid), .s_ready_o(r0), .gtwiz_userdata_tx_o(d0),
        .txheader_o(h0), .txsequence_o(q0), .idle_insert_o(i0), .header_err_o(e0)
    );

    tx_gearbox_feed #(.P_SCRAMBLE(1'b1)) dut_scr (
        .clk_i(clk), .rst_n_i(rst_n), .s_data_i(s_data), .s_header_i(s_header),
        .s_valid_i(s_valid), .s_ready_o(r1), .gtwiz_userdata_tx_o(d1),
        .txheader_o(h1), .txsequence_o(q1), .idle_insert_o(i1), .header_err_o(e1)
    );

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: slot timing is derived from the cycle index since release.
    bit          started;
    int          k;
    bit          pend;
    logic [31:0] ex_d0, ex_d1, hi_0, hi_1;
    logic [1:0]  ex_h;
    bit          ex_idle, ex_err;
    bit          txq[$];
    bit          rxq[$];
    logic [31:0] lo_seen;
    logic [63:0] sent_pay;
    int          accepted;
    bit          last_slot;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        started = 0; k = 0; pend = 0;
        ex_d0 = '0; ex_d1 = '0; hi_0 = '0; hi_1 = '0;
        ex_h = 2'b00; ex_idle = 0; ex_err = 0;
        txq.delete(); rxq.delete();
        for (int i = 0; i < 58; i++) begin
            txq.push_back(1'b1);
            rxq.push_back(1'b1);
        end
    endtask

    // Serial x^58+x^39+1 scrambler over the whole transmitted bit history.
    task automatic scr_ref(input logic [63:0] din, output logic [63:0] dout);
        bit b;
        for (int i = 0; i < 64; i++) begin
            b = din[i] ^ txq[txq.size()-39] ^ txq[txq.size()-58];
            dout[i] = b;
            txq.push_back(b);
        end
    endtask

    task automatic dscr_ref(input logic [63:0] rx, output logic [63:0] dout);
        for (int i = 0; i < 64; i++) begin
            dout[i] = rx[i] ^ rxq[rxq.size()-39] ^ rxq[rxq.size()-58];
            rxq.push_back(rx[i]);
        end
    endtask

    function automatic bit m_ready();
        return started && (k % 2 == 0) && ((k / 2) % 33 != 32);
    endfunction

    task automatic check_outputs();
        chk("data_plain", 64'(d0), 64'(ex_d0));
        chk("data_scr",   64'(d1), 64'(ex_d1));
        chk("hdr_plain",  64'(h0), 64'(ex_h));
        chk("hdr_scr",    64'(h1), 64'(ex_h));
        chk("seq_plain",  64'(q0), started ? 64'((k / 2) % 33) : 64'd0);
        chk("seq_scr",    64'(q1), started ? 64'((k / 2) % 33) : 64'd0);
        chk("idle_plain", 64'(i0), 64'(ex_idle));
        chk("idle_scr",   64'(i1), 64'(ex_idle));
        chk("err_plain",  64'(e0), 64'(ex_err));
        chk("err_scr",    64'(e1), 64'(ex_err));
    endtask

    // Called at a negedge; drives one cycle, checks registered outputs #1 after the edge.
    task automatic step(input bit v, input logic [1:0] h, input logic [63:0] d);
        bit          slot;
        bit          had_hi;
        logic [1:0]  bh;
        logic [63:0] bp, sp, rec;
        s_valid = v; s_header = h; s_data = d;
        #1;
        slot = m_ready();
        chk("ready_plain", 64'(r0), 64'(slot));
        chk("ready_scr",   64'(r1), 64'(slot));
        bh = 2'b00; bp = '0; sp = '0; had_hi = 0;
        if (slot) begin
            bh = v ? h : 2'b10;
            bp = v ? d : IDLE_BLK;
            scr_ref(bp, sp);
            if (v) accepted++;
        end
        @(posedge clk);
        #1;
        if (slot) begin
            ex_h = bh; ex_d0 = bp[31:0]; ex_d1 = sp[31:0];
            hi_0 = bp[63:32]; hi_1 = sp[63:32]; pend = 1;
            ex_idle = !v; ex_err = (bh == 2'b00) || (bh == 2'b11);
            sent_pay = bp;
        end else begin
            ex_idle = 0; ex_err = 0;
            if (pend) begin
                ex_d0 = hi_0; ex_d1 = hi_1; pend = 0; had_hi = 1;
            end
        end
        if (started) k++;
        else begin started = 1; k = 0; end
        check_outputs();
        if (slot) lo_seen = d1;
        if (had_hi) begin
            dscr_ref({d1, lo_seen}, rec);
            chk("loopback", rec, sent_pay);
        end
        last_slot = slot;
        @(negedge clk);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("ready_rst_plain", 64'(r0), 64'd0);
        chk("ready_rst_scr",   64'(r1), 64'd0);
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_outputs();
            chk("ready_rst_plain", 64'(r0), 64'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_pre_edge", 64'(r0), 64'd0);
    endtask

    initial begin
        int          cnt;
        int          guard;
        int          seq_max;
        logic [63:0] blk;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_header = 2'b00;
        accepted = 0; last_slot = 0; lo_seen = '0; sent_pay = '0;
        model_reset();
        @(negedge clk);
        do_reset(3);

        // Idle insertion with no source blocks
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 2'b01, 64'hDEAD_BEEF_DEAD_BEEF);
            if (i0) cnt++;
            if (i == 1) chk("idle_lo_word", 64'(d0), 64'h1E);
            if (i == 2) chk("idle_hi_word", 64'(d0), 64'h0);
            if (i == 2) chk("idle_hdr", 64'(h0), 64'h2);
        end
        chk("idle_pulse_count", 64'(cnt), 64'd5);

        // Single known block
        step(1'b0, 2'b01, '0);
        step(1'b1, 2'b01, 64'h0123_4567_89AB_CDEF);
        chk("blk_lo", 64'(d0), 64'h89AB_CDEF);
        chk("blk_hdr_lo", 64'(h0), 64'h1);
        step(1'b0, 2'b01, '0);
        chk("blk_hi", 64'(d0), 64'h0123_4567);
        chk("blk_hdr_hi", 64'(h0), 64'h1);

        // Invalid header is flagged and passed through
        step(1'b1, 2'b11, {$urandom, $urandom});
        chk("hdr11_err", 64'(e0), 64'd1);
        chk("hdr11_tx", 64'(h0), 64'h3);
        step(1'b0, 2'b01, '0);
        chk("hdr11_err_clear", 64'(e0), 64'd0);
        step(1'b1, 2'b01, {$urandom, $urandom});
        chk("after_hdr11_hdr", 64'(h0), 64'h1);
        step(1'b0, 2'b01, '0);

        // Continuous source for 140 cycles
        cnt = 0; seq_max = 0;
        for (int i = 0; i < 140; i++) begin
            if (i < 66 && r0) cnt++;
            step(1'b1, 2'b01, {$urandom, $urandom});
            if (int'(q0) > seq_max) seq_max = int'(q0);
        end
        chk("blocks_per_66", 64'(cnt), 64'd32);
        chk("seq_max_seen", 64'(seq_max), 64'd32);

        // 1000 random blocks, occasional gaps and random headers
        accepted = 0; guard = 0;
        while (accepted < 1000 && guard < 5000) begin
            guard++;
            step(($urandom % 5) != 0, 2'($urandom), {$urandom, $urandom});
        end
        chk("accepted_1000", 64'(accepted), 64'd1000);

        // Reset pulsed while the second word is pending
        guard = 0;
        while (!m_ready() && guard < 100) begin
            guard++;
            step(1'b0, 2'b01, '0);
        end
        chk("align_found", 64'(m_ready()), 64'd1);
        step(1'b1, 2'b01, 64'hAAAA_BBBB_CCCC_DDDD);
        chk("pre_rst_phase1", 64'(last_slot), 64'd1);
        do_reset(0);
        blk = 64'h1111_2222_3333_4444;
        step(1'b1, 2'b01, blk);
        chk("post_rst_no_hi", 64'(d0), 64'h0);
        step(1'b1, 2'b01, blk);
        chk("post_rst_first_lo", 64'(d0), 64'h3333_4444);
        step(1'b0, 2'b01, '0);
        chk("post_rst_hi", 64'(d0), 64'h1111_2222);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
